key_debounce_pio: RTL

- Conditions raw push-button inputs before they reach the 8-bit PIO input port of the system.
- Per key: synchronises the raw input to sys_clk and debounces it with a shared millisecond-tick prescaler.
- Per key outputs: a clean level, one-cycle press/release strobes, and sticky write-1-to-clear event flags that software polls.
- Sits between the board key pins and the PIO input bus, on the 50 MHz board clock.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 123 ++++++++++++
 rtl/key_debounce_pio.sv | 58 +++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and width helpers for the key debounce block.
package key_pkg;

    typedef enum logic [1:0] {UP, WAIT_DN, DOWN, WAIT_UP} key_state_t;

    // Prescaler counter width for a TICK_DIV-cycle period.
    function automatic int unsigned div_width(input int unsigned tick_div);
        return (tick_div < 2) ? 1 : $clog2(tick_div);
    endfunction

    // Channel counter width able to hold 0..DEBOUNCE_TICKS.
    function automatic int unsigned cnt_width(input int unsigned debounce_ticks);
        return (debounce_ticks < 1) ? 1 : $clog2(debounce_ticks + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM with tick counter,
// registered level/press/release outputs and a sticky pending flag.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    input  logic tick,
    input  logic event_clr,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic event_pending
);

    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

    logic [1:0]      sync_q;
    logic            s;
    key_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            pend_q, pend_d;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q  <= {2{ACTIVE_LOW}};
            state_q <= UP;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            UP: begin
                if (s) begin
                    state_d = WAIT_DN;
                    cnt_d   = '0;
                end
            end
            WAIT_DN: begin
                if (!s) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = DOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            DOWN: begin
                if (!s) begin
                    state_d = WAIT_UP;
                    cnt_d   = '0;
                end
            end
            WAIT_UP: begin
                if (s) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = UP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    // A clear landing in the strobe cycle loses to the set still held by press_q.
    always_comb begin
        level_d   = (state_d == DOWN) || (state_d == WAIT_UP);
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        pend_d    = press_d | press_q | (pend_q & ~event_clr);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            pend_q    <= pend_d;
        end
    end

    assign key_level     = level_q;
    assign key_press     = press_q;
    assign key_release   = release_q;
    assign event_pending = pend_q;

endmodule

// File: rtl/key_debounce_pio.sv
// Key conditioning for the PIO input port: shared debounce-tick prescaler
// feeding NUM_KEYS independent debounce channels.
module key_debounce_pio
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = 8,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] event_clr,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] event_pending,
    output logic                tick
);

    localparam int unsigned     DivW    = div_width(TICK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DivLast);

    always_comb begin
        div_d = tick ? '0 : div_q + DivW'(1);
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .sys_clk       (sys_clk),
            .sys_rst       (sys_rst),
            .key_in        (key_in[i]),
            .tick          (tick),
            .event_clr     (event_clr[i]),
            .key_level     (key_level[i]),
            .key_press     (key_press[i]),
            .key_release   (key_release[i]),
            .event_pending (event_pending[i])
        );
    end

endmodule
